// File: rtl/spi_flash_pkg.sv
// Shared opcodes, request/response codes and FSM states for the SPI flash command sequencer.
package spi_flash_pkg;

    localparam logic [7:0] OPC_WREN = 8'h06;
    localparam logic [7:0] OPC_RDSR = 8'h05;
    localparam logic [7:0] OPC_READ = 8'h03;
    localparam logic [7:0] OPC_PROG = 8'h02;
    localparam logic [7:0] OPC_SE   = 8'h20;
    localparam logic [7:0] OPC_RDID = 8'h9F;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_PROG  = 2'd1,
        OP_ERASE = 2'd2,
        OP_RDID  = 2'd3
    } req_op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_BAD_LEN = 2'd1,
        ERR_TIMEOUT = 2'd2
    } resp_err_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN,
        S_WWAIT,
        S_MAIN,
        S_WAIT,
        S_GAP,
        S_POLL,
        S_PWAIT,
        S_RESP
    } state_e;

endpackage

// File: rtl/spi_flash_seq.sv
// Request-level sequencer driving spi_flash_ctrl: WREN, main command, RDSR polling, one response.
// Optional SPI_SEQ_TIMEOUT_EN adds a poll counter that reports TIMEOUT after TIMEOUT_POLLS busy polls.
module spi_flash_seq
    import spi_flash_pkg::*;
#(
    parameter int POLL_GAP      = 16,
    parameter int TIMEOUT_POLLS = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_len,
    output logic        resp_valid,
    output logic [1:0]  resp_err,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        fl_cmd_valid,
    output logic [7:0]  fl_cmd_opcode,
    output logic [23:0] fl_cmd_addr,
    output logic [15:0] fl_cmd_len,
    output logic        fl_cmd_has_addr,
    output logic        fl_cmd_is_read,
    output logic        fl_cmd_is_write,
    input  logic        fl_cmd_ready,
    output logic [7:0]  fl_wr_data,
    output logic        fl_wr_valid,
    input  logic        fl_wr_ready,
    input  logic [7:0]  fl_rd_data,
    input  logic        fl_rd_valid,
    output logic        fl_rd_ready,
    input  logic        fl_done
);

    localparam int GAP_W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);

    state_e          state, state_nx;
    req_op_e         op_q;
    logic [23:0]     addr_q;
    logic [15:0]     len_q;
    resp_err_e       err_q, err_nx;
    logic [GAP_W-1:0] gap_cnt;
    logic            wip_q, wip_now;
    logic            len_bad;
    logic [16:0]     page_end;
    logic            wr_conn, rd_conn;

    // A program must stay inside one 256-byte page.
    assign page_end = {9'd0, req_addr[7:0]} + {1'b0, req_len};

    always_comb begin
        len_bad = 1'b0;
        case (req_op_e'(req_op))
            OP_PROG: len_bad = (req_len == 16'd0) || (req_len > 16'd256) || (page_end > 17'd256);
            OP_READ: len_bad = (req_len == 16'd0);
            default: len_bad = 1'b0;
        endcase
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    logic [15:0] poll_cnt;
    logic        poll_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            poll_cnt <= '0;
        else if (state == S_MAIN && fl_cmd_ready)
            poll_cnt <= '0;
        else if (state == S_POLL && fl_cmd_ready)
            poll_cnt <= poll_cnt + 16'd1;
    end

    assign poll_limit = (int'(poll_cnt) >= TIMEOUT_POLLS);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_POLLS;
`endif

    // The status byte and fl_done may coincide, so take the live byte when present.
    assign wip_now = fl_rd_valid ? fl_rd_data[0] : wip_q;

    always_comb begin
        state_nx        = state;
        err_nx          = err_q;
        fl_cmd_valid    = 1'b0;
        fl_cmd_opcode   = 8'h00;
        fl_cmd_addr     = 24'h0;
        fl_cmd_len      = 16'h0;
        fl_cmd_has_addr = 1'b0;
        fl_cmd_is_read  = 1'b0;
        fl_cmd_is_write = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (len_bad) begin
                        state_nx = S_RESP;
                        err_nx   = ERR_BAD_LEN;
                    end else if (req_op_e'(req_op) == OP_PROG || req_op_e'(req_op) == OP_ERASE) begin
                        state_nx = S_WREN;
                    end else begin
                        state_nx = S_MAIN;
                    end
                end
            end
            S_WREN: begin
                fl_cmd_valid  = 1'b1;
                fl_cmd_opcode = OPC_WREN;
                if (fl_cmd_ready) state_nx = S_WWAIT;
            end
            S_WWAIT: if (fl_done) state_nx = S_MAIN;
            S_MAIN: begin
                fl_cmd_valid = 1'b1;
                case (op_q)
                    OP_READ: begin
                        fl_cmd_opcode   = OPC_READ;
                        fl_cmd_addr     = addr_q;
                        fl_cmd_len      = len_q;
                        fl_cmd_has_addr = 1'b1;
                        fl_cmd_is_read  = 1'b1;
                    end
                    OP_PROG: begin
                        fl_cmd_opcode   = OPC_PROG;
                        fl_cmd_addr     = addr_q;
                        fl_cmd_len      = len_q;
                        fl_cmd_has_addr = 1'b1;
                        fl_cmd_is_write = 1'b1;
                    end
                    OP_ERASE: begin
                        fl_cmd_opcode   = OPC_SE;
                        fl_cmd_addr     = addr_q;
                        fl_cmd_has_addr = 1'b1;
                    end
                    default: begin
                        fl_cmd_opcode  = OPC_RDID;
                        fl_cmd_len     = 16'd3;
                        fl_cmd_is_read = 1'b1;
                    end
                endcase
                if (fl_cmd_ready) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (fl_done) begin
                    if (op_q == OP_READ || op_q == OP_RDID) begin
                        state_nx = S_RESP;
                        err_nx   = ERR_OK;
                    end else begin
                        state_nx = S_GAP;
                    end
                end
            end
            S_GAP: if (gap_cnt == GAP_W'(POLL_GAP - 1)) state_nx = S_POLL;
            S_POLL: begin
                fl_cmd_valid   = 1'b1;
                fl_cmd_opcode  = OPC_RDSR;
                fl_cmd_len     = 16'd1;
                fl_cmd_is_read = 1'b1;
                if (fl_cmd_ready) state_nx = S_PWAIT;
            end
            S_PWAIT: begin
                if (fl_done) begin
                    if (!wip_now) begin
                        state_nx = S_RESP;
                        err_nx   = ERR_OK;
`ifdef SPI_SEQ_TIMEOUT_EN
                    end else if (poll_limit) begin
                        state_nx = S_RESP;
                        err_nx   = ERR_TIMEOUT;
`endif
                    end else begin
                        state_nx = S_GAP;
                    end
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= OP_READ;
            addr_q  <= '0;
            len_q   <= '0;
            err_q   <= ERR_OK;
            gap_cnt <= '0;
            wip_q   <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= err_nx;
            if (state == S_IDLE && req_valid) begin
                op_q   <= req_op_e'(req_op);
                addr_q <= req_addr;
                len_q  <= req_len;
            end
            gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (state == S_PWAIT && fl_rd_valid) wip_q <= fl_rd_data[0];
        end
    end

    // Bulk data only flows while the main command of the matching op is in flight.
    assign wr_conn = (state == S_WAIT) && (op_q == OP_PROG);
    assign rd_conn = (state == S_WAIT) && (op_q == OP_READ || op_q == OP_RDID);

    assign fl_wr_data  = wr_data;
    assign fl_wr_valid = wr_conn && wr_valid;
    assign wr_ready    = wr_conn && fl_wr_ready;
    assign rd_data     = fl_rd_data;
    assign rd_valid    = rd_conn && fl_rd_valid;
    assign fl_rd_ready = (state == S_PWAIT) || (rd_conn && rd_ready);

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_err   = err_q;

endmodule

// File: tb/tb_spi_flash_seq.sv
// Randomized bench for spi_flash_seq with a transaction-level flash ctrl model and expected command lists.
module tb_spi_flash_seq;

    localparam int GAP    = 4;
    localparam int TPOLLS = 4;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [23:0] req_addr;
    logic [15:0] req_len;
    logic        resp_valid;
    logic [1:0]  resp_err;
    logic [7:0]  wr_data;
    logic        wr_valid, wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid, rd_ready;
    logic        fl_cmd_valid;
    logic [7:0]  fl_cmd_opcode;
    logic [23:0] fl_cmd_addr;
    logic [15:0] fl_cmd_len;
    logic        fl_cmd_has_addr, fl_cmd_is_read, fl_cmd_is_write, fl_cmd_ready;
    logic [7:0]  fl_wr_data;
    logic        fl_wr_valid, fl_wr_ready;
    logic [7:0]  fl_rd_data;
    logic        fl_rd_valid, fl_rd_ready;
    logic        fl_done;

    spi_flash_seq #(.POLL_GAP(GAP), .TIMEOUT_POLLS(TPOLLS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_len(req_len),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .fl_cmd_valid(fl_cmd_valid), .fl_cmd_opcode(fl_cmd_opcode), .fl_cmd_addr(fl_cmd_addr),
        .fl_cmd_len(fl_cmd_len), .fl_cmd_has_addr(fl_cmd_has_addr),
        .fl_cmd_is_read(fl_cmd_is_read), .fl_cmd_is_write(fl_cmd_is_write),
        .fl_cmd_ready(fl_cmd_ready),
        .fl_wr_data(fl_wr_data), .fl_wr_valid(fl_wr_valid), .fl_wr_ready(fl_wr_ready),
        .fl_rd_data(fl_rd_data), .fl_rd_valid(fl_rd_valid), .fl_rd_ready(fl_rd_ready),
        .fl_done(fl_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [50:0] mk(input logic [7:0] o, input logic [23:0] a, input logic [15:0] l,
                                       input logic ha, input logic ir, input logic iw);
        return {o, a, l, ha, ir, iw};
    endfunction

    function automatic logic [50:0] cmd_vec();
        return {fl_cmd_opcode, fl_cmd_addr, fl_cmd_len, fl_cmd_has_addr, fl_cmd_is_read, fl_cmd_is_write};
    endfunction

    // flash ctrl model state and transaction logs
    int          cyc, fm_ph, fm_dly, fm_idx, fm_left, wip_left, cmd_dly;
    bit          fm_wait, pend_req;
    logic [7:0]  fm_op;
    logic [50:0] fm_first;
    logic [7:0]  rd_pat[$];
    logic [7:0]  wr_src[$];
    logic [7:0]  flw_log[$];
    logic [7:0]  usr_rd[$];
    logic [50:0] cmd_log[$];
    int          wr_idx, resp_n, resp_cyc, acc_cyc;
    logic [1:0]  resp_e;

    task automatic cycle();
        logic [7:0] rnd;
        @(negedge clk);
        cyc++;
        if (!pend_req) begin
            req_op   = 2'($urandom);
            req_addr = 24'($urandom);
            req_len  = 16'($urandom);
        end
        req_valid    = pend_req;
        fl_cmd_ready = 1'b0;
        fl_done      = 1'b0;
        fl_rd_valid  = 1'b0;
        fl_wr_ready  = 1'b0;
        rnd          = 8'($urandom);
        fl_rd_data   = rnd;
        case (fm_ph)
            0: if (fl_cmd_valid) begin
                if (!fm_wait) begin
                    fm_wait  = 1'b1;
                    fm_dly   = cmd_dly;
                    fm_first = cmd_vec();
                end else begin
                    chk("cmd_stable", 64'(cmd_vec()), 64'(fm_first));
                end
                if (fm_dly == 0) fl_cmd_ready = 1'b1;
                else fm_dly--;
            end
            1: begin
                fl_rd_valid = ($urandom_range(0, 3) != 0);
                if (fm_op == 8'h05) fl_rd_data = {rnd[7:1], (wip_left > 0)};
                else if (fm_idx < rd_pat.size()) fl_rd_data = rd_pat[fm_idx];
            end
            2: fl_wr_ready = ($urandom_range(0, 3) != 0);
            3: begin
                fl_done = 1'b1;
                fm_ph   = 0;
            end
            default: fm_ph = 0;
        endcase
        rd_ready = ($urandom_range(0, 3) != 0);
        wr_valid = (wr_idx < wr_src.size()) && ($urandom_range(0, 3) != 0);
        wr_data  = wr_valid ? wr_src[wr_idx] : 8'($urandom);
        #1;
        if (req_valid && req_ready) begin
            pend_req = 1'b0;
            acc_cyc  = cyc;
        end
        if (fm_ph == 0 && fl_cmd_valid && fl_cmd_ready) begin
            cmd_log.push_back(cmd_vec());
            fm_wait = 1'b0;
            fm_op   = fl_cmd_opcode;
            fm_idx  = 0;
            fm_left = int'(fl_cmd_len);
            if (fl_cmd_is_read && fm_left != 0) fm_ph = 1;
            else if (fl_cmd_is_write && fm_left != 0) fm_ph = 2;
            else fm_ph = 3;
        end else if (fm_ph == 1 && fl_rd_valid && fl_rd_ready) begin
            if (fm_op == 8'h05 && wip_left > 0) wip_left--;
            fm_idx++;
            if (fm_idx == fm_left) fm_ph = 3;
        end else if (fm_ph == 2 && fl_wr_valid && fl_wr_ready) begin
            flw_log.push_back(fl_wr_data);
            fm_idx++;
            if (fm_idx == fm_left) fm_ph = 3;
        end
        if (rd_valid && rd_ready) usr_rd.push_back(rd_data);
        if (wr_valid && wr_ready) wr_idx++;
        if (resp_valid) begin
            resp_n++;
            resp_e   = resp_err;
            resp_cyc = cyc;
        end
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        rst = 1'b1;
        pend_req = 1'b0; req_valid = 1'b0; wr_valid = 1'b1;
        fl_cmd_ready = 1'b0; fl_done = 1'b0;
        fl_wr_ready = 1'b1; fl_rd_valid = 1'b1; rd_ready = 1'b1;
        fm_ph = 0; fm_wait = 1'b0;
        #1;
        if (check) begin
            chk("rst_cmd", 64'({fl_cmd_valid, cmd_vec()}), 64'(0));
            chk("rst_resp", 64'({resp_valid, resp_err}), 64'(0));
            chk("rst_wr", 64'({wr_ready, fl_wr_valid}), 64'(0));
            chk("rst_rd", 64'({fl_rd_ready, rd_valid}), 64'(0));
            chk("rst_req_ready", 64'(req_ready), 64'(1));
        end
        repeat (2) @(negedge clk);
        wr_valid = 1'b0; fl_wr_ready = 1'b0; fl_rd_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic start_req(input logic [1:0] op, input logic [23:0] a, input logic [15:0] l,
                             input int busy, input int dly, input bit dirpat);
        rd_pat.delete(); wr_src.delete(); flw_log.delete(); usr_rd.delete(); cmd_log.delete();
        wr_idx = 0; resp_n = 0; acc_cyc = -1; resp_cyc = -1;
        wip_left = busy; cmd_dly = dly;
        if (op == 2'd0) for (int i = 0; i < int'(l); i++) rd_pat.push_back(dirpat ? 8'(8'hA0 + i) : 8'($urandom));
        if (op == 2'd3) rd_pat = '{8'hEF, 8'h40, 8'h18};
        if (op == 2'd1 && l <= 16'd256) for (int i = 0; i < int'(l); i++) wr_src.push_back(8'($urandom));
        req_op = op; req_addr = a; req_len = l;
        pend_req = 1'b1;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [23:0] a, input logic [15:0] l,
                          input int busy, input int dly, input bit dirpat);
        logic [50:0] exp_cmd[$];
        bit          bad;
        int          polls, n;
        logic [1:0]  e;
        bad = (op == 2'd1 && (l == 0 || l > 256 || int'(a[7:0]) + int'(l) > 256)) || (op == 2'd0 && l == 0);
        e = 2'd0;
        polls = busy + 1;
`ifdef SPI_SEQ_TIMEOUT_EN
        if (busy >= TPOLLS) begin polls = TPOLLS; e = 2'd2; end
`endif
        if (bad) e = 2'd1;
        else if (op == 2'd0) exp_cmd.push_back(mk(8'h03, a, l, 1, 1, 0));
        else if (op == 2'd3) exp_cmd.push_back(mk(8'h9F, 0, 16'd3, 0, 1, 0));
        else begin
            exp_cmd.push_back(mk(8'h06, 0, 0, 0, 0, 0));
            if (op == 2'd1) exp_cmd.push_back(mk(8'h02, a, l, 1, 0, 1));
            else exp_cmd.push_back(mk(8'h20, a, 0, 1, 0, 0));
            for (int i = 0; i < polls; i++) exp_cmd.push_back(mk(8'h05, 0, 16'd1, 0, 1, 0));
        end
        start_req(op, a, l, busy, dly, dirpat);
        n = 0;
        while (resp_n == 0 && n < 4000) begin cycle(); n++; end
        chk("resp_cnt", 64'(resp_n), 64'(1));
        chk("resp_err", 64'(resp_e), 64'(e));
        if (bad) chk("bad_latency", 64'(resp_cyc - acc_cyc), 64'(1));
        chk("cmd_cnt", 64'(cmd_log.size()), 64'(exp_cmd.size()));
        for (int i = 0; i < exp_cmd.size() && i < cmd_log.size(); i++)
            chk($sformatf("cmd%0d", i), 64'(cmd_log[i]), 64'(exp_cmd[i]));
        if (!bad && (op == 2'd0 || op == 2'd3)) begin
            chk("rd_cnt", 64'(usr_rd.size()), 64'(rd_pat.size()));
            for (int i = 0; i < rd_pat.size() && i < usr_rd.size(); i++)
                chk("rd_byte", 64'(usr_rd[i]), 64'(rd_pat[i]));
        end
        if (!bad && op == 2'd1) begin
            chk("wr_cnt", 64'(flw_log.size()), 64'(wr_src.size()));
            for (int i = 0; i < wr_src.size() && i < flw_log.size(); i++)
                chk("wr_byte", 64'(flw_log[i]), 64'(wr_src[i]));
        end
        cycle();
        chk("resp_hold", 64'({resp_valid, resp_err}), 64'({1'b0, e}));
    endtask

    initial begin
        int n;
        logic [1:0]  op;
        logic [23:0] a;
        logic [15:0] l;
        clk = 1'b0; rst = 1'b1; cyc = 0; fm_ph = 0; fm_wait = 1'b0; pend_req = 1'b0;
        req_valid = 1'b0; req_op = 0; req_addr = 0; req_len = 0;
        wr_data = 0; wr_valid = 0; rd_ready = 0;
        fl_cmd_ready = 0; fl_wr_ready = 0; fl_rd_data = 0; fl_rd_valid = 0; fl_done = 0;
        wip_left = 0; cmd_dly = 0; wr_idx = 0; resp_n = 0; resp_e = 0; fm_op = 0; fm_first = 0;
        do_reset(1'b1);

        do_req(2'd0, 24'h000100, 16'd4, 0, 1, 1'b1);
        do_req(2'd1, 24'h0000F0, 16'd16, 2, 0, 1'b0);
        do_req(2'd1, 24'h0000F8, 16'd16, 0, 0, 1'b0);
        do_req(2'd0, 24'h000020, 16'd0, 0, 0, 1'b0);
        do_req(2'd1, 24'h000000, 16'd256, 1, 2, 1'b0);
        do_req(2'd1, 24'h000001, 16'd256, 0, 0, 1'b0);
        do_req(2'd3, 24'h123456, 16'd77, 0, 5, 1'b0);

`ifdef SPI_SEQ_TIMEOUT_EN
        do_req(2'd2, 24'h001000, 16'd0, 1000, 1, 1'b0);
`else
        start_req(2'd2, 24'h001000, 16'd0, 1000, 1, 1'b0);
        repeat (300) cycle();
        chk("stuck_no_resp", 64'(resp_n), 64'(0));
        chk("stuck_polling", 64'(cmd_log.size() >= 6), 64'(1));
        do_reset(1'b0);
`endif

        // Leave a non-zero resp_err behind, then reset while the sequencer sits in S_GAP.
        do_req(2'd1, 24'h0000FF, 16'd2, 0, 0, 1'b0);
        start_req(2'd2, 24'h002000, 16'd0, 5, 0, 1'b0);
        n = 0;
        while (!(cmd_log.size() == 2 && fm_ph == 0 && !fm_wait) && n < 200) begin cycle(); n++; end
        chk("reach_gap", 64'(n < 200), 64'(1));
        do_reset(1'b1);
        chk("gap_reset_no_resp", 64'(resp_n), 64'(0));
        do_req(2'd0, 24'h00ABCD, 16'd5, 0, 0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            op = 2'($urandom);
            a  = 24'($urandom);
            case (op)
                2'd0: l = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 24));
                2'd1: l = ($urandom_range(0, 2) != 0) ? 16'($urandom_range(1, 256 - int'(a[7:0])))
                                                      : 16'($urandom_range(0, 300));
                default: l = 16'($urandom);
            endcase
            do_req(op, a, l, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
